serial_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_subtractor_bit.sv | 13 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the serial arithmetic cells.
package serial_arith_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic bit width_ok(input int unsigned w);
    return (w >= 1) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit difference/borrow cell: the subtract mirror of a full adder.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first through one subtract cell, registered borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_subtractor: WIDTH out of range");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bi;
  logic             d;
  logic             bo;
  logic             last;

  full_subtractor_bit u_cell (
    .a  (xs[0]),
    .b  (ys[0]),
    .bi (bi),
    .d  (d),
    .bo (bo)
  );

  // New difference bit enters at the MSB so bit 0 lands at res[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d;
    end else begin : g_res_wn
      assign res_next = {d, res[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      xs     <= '0;
      ys     <= '0;
      res    <= '0;
      bi     <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            xs    <= x;
            ys    <= y;
            res   <= '0;
            bi    <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          xs  <= xs >> 1;
          ys  <= ys >> 1;
          res <= res_next;
          bi  <= bo;
          cnt <= cnt + 1'b1;
          // Outputs are loaded on the final shift edge so they are valid alongside done.
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= bo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8, 4 and 1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, busy8, done8, borrow8;
  logic [7:0] x8 = '0, y8 = '0, diff8;
  logic       start4 = 1'b0, busy4, done4, borrow4;
  logic [3:0] x4 = '0, y4 = '0, diff4;
  logic       start1 = 1'b0, busy1, done1, borrow1;
  logic [0:0] x1 = '0, y1 = '0, diff1;

  int tests_run = 0;
  int failures  = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );
  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );
  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  function automatic logic [31:0] ref_diff(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] full;
    full = {1'b0, a} - {1'b0, b};
    return full[31:0] & ((33'h1 << w) - 1);
  endfunction

  function automatic logic ref_borrow(input logic [31:0] a, input logic [31:0] b);
    return a < b;
  endfunction

  task automatic set_in(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    case (w)
      8: begin x8 = a[7:0]; y8 = b[7:0]; start8 = s; end
      4: begin x4 = a[3:0]; y4 = b[3:0]; start4 = s; end
      default: begin x1 = a[0:0]; y1 = b[0:0]; start1 = s; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : (w == 4) ? done4 : done1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
  endfunction
  function automatic logic [31:0] get_diff(input int w);
    return (w == 8) ? 32'(diff8) : (w == 4) ? 32'(diff4) : 32'(diff1);
  endfunction
  function automatic logic get_borrow(input int w);
    return (w == 8) ? borrow8 : (w == 4) ? borrow4 : borrow1;
  endfunction

  // Pulses start (sampled on the next edge), waits for done; lat counts edges from the sampling edge.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic bo, output int lat, output int bcnt);
    set_in(w, a, b, 1'b1);
    @(posedge clk); #1;
    set_in(w, a, b, 1'b0);
    lat = 1;
    bcnt = 0;
    while (!get_done(w) && lat < 100) begin
      if (get_busy(w)) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    d  = get_diff(w);
    bo = get_borrow(w);
  endtask

  task automatic check_op(input string name, input int w, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic bo;
    int lat, bcnt;
    do_op(w, a, b, d, bo, lat, bcnt);
    tests_run++;
    if (d !== ref_diff(w, a, b) || bo !== ref_borrow(a, b) || lat != w + 1 || bcnt != w) begin
      failures++;
      $display("FAIL %s w=%0d x=%h y=%h: got diff=%h borrow=%b lat=%0d busy=%0d, want diff=%h borrow=%b lat=%0d busy=%0d",
               name, w, a, b, d, bo, lat, bcnt, ref_diff(w, a, b), ref_borrow(a, b), w + 1, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy8, done8, diff8, borrow8} !== 11'b0 || {busy4, done4, diff4, borrow4} !== 7'b0 ||
        {busy1, done1, diff1, borrow1} !== 4'b0) begin
      failures++;
      $display("FAIL reset_values: got w8=%b%b%h%b w4=%b%b%h%b w1=%b%b%h%b, want all zero",
               busy8, done8, diff8, borrow8, busy4, done4, diff4, borrow4, busy1, done1, diff1, borrow1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op("basic_5a_23", 8, 32'h5A, 32'h23);
    check_op("underflow_10_20", 8, 32'h10, 32'h20);
    check_op("underflow_00_01", 8, 32'h00, 32'h01);
    check_op("equal_ff", 8, 32'hFF, 32'hFF);
    check_op("chain_80_7f", 8, 32'h80, 32'h7F);
    tests_run++;
    if (diff8 !== 8'h01 || borrow8 !== 1'b0) begin
      failures++;
      $display("FAIL chain_const: got diff=%h borrow=%b, want diff=01 borrow=0", diff8, borrow8);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) check_op("random8", 8, $urandom_range(255), $urandom_range(255));
  endtask

  task automatic test_start_ignored();
    int lat;
    set_in(8, 32'hC3, 32'h41, 1'b1);
    @(posedge clk); #1;
    set_in(8, 32'hC3, 32'h41, 1'b0);
    lat = 1;
    repeat (2) begin @(posedge clk); #1; lat++; end
    set_in(8, 32'h01, 32'h02, 1'b1);
    @(posedge clk); #1; lat++;
    set_in(8, 32'h01, 32'h02, 1'b0);
    while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
    tests_run++;
    if (diff8 !== 8'h82 || borrow8 !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL start_in_shift: got diff=%h borrow=%b lat=%0d, want diff=82 borrow=0 lat=9", diff8, borrow8, lat);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL no_queued_op: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a2, b2;
    int gap;
    a2 = $urandom_range(255);
    b2 = $urandom_range(255);
    check_op("b2b_first", 8, 32'h3C, 32'hA5);
    set_in(8, a2, b2, 1'b1);
    @(posedge clk); #1;
    set_in(8, a2, b2, 1'b0);
    gap = 1;
    while (!done8 && gap < 100) begin @(posedge clk); #1; gap++; end
    tests_run++;
    if (gap != 9 || 32'(diff8) !== ref_diff(8, a2, b2) || borrow8 !== ref_borrow(a2, b2)) begin
      failures++;
      $display("FAIL back_to_back: got gap=%0d diff=%h borrow=%b, want gap=9 diff=%h borrow=%b",
               gap, diff8, borrow8, ref_diff(8, a2, b2), ref_borrow(a2, b2));
    end
  endtask

  task automatic test_mid_reset();
    check_op("pre_reset", 8, 32'h10, 32'h20);
    set_in(8, 32'h77, 32'h11, 1'b1);
    @(posedge clk); #1;
    set_in(8, 32'h77, 32'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_shift_reset: got busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0", busy8, done8, diff8, borrow8);
    end
    check_op("after_reset", 8, 32'hE1, 32'h1E);
    rst = 1'b1;
    set_in(8, 32'h55, 32'h66, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(8, 32'h55, 32'h66, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00) begin
      failures++;
      $display("FAIL rst_with_start: got busy=%b done=%b diff=%h, want 0 0 00", busy8, done8, diff8);
    end
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        check_op("exh4", 4, 32'(a), 32'(b));
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        check_op("exh1", 1, 32'(a), 32'(b));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
